// File: rtl/alu_input_ctrl_pkg.sv
// Shared types and constants for the ALU input front end (alu_input_ctrl).
// Optional input synchronizer is enabled by defining ALU_IN_SYNC_EN.
package alu_in_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned MODE_W = 2;

    localparam logic [OP_W-1:0] OP_0 = 4'b0001;
    localparam logic [OP_W-1:0] OP_1 = 4'b0010;
    localparam logic [OP_W-1:0] OP_2 = 4'b0100;
    localparam logic [OP_W-1:0] OP_3 = 4'b1000;

    // Encodings kept as explicit constants so they match the legacy state values.
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_REL = 1'b1;

    typedef enum logic [0:0] {
        IDLE     = ST_IDLE,
        WAIT_REL = ST_WAIT_REL
    } state_e;

    function automatic logic is_one_hot(input logic [OP_W-1:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/alu_input_ctrl_if.sv
// Switch/button inputs and captured-transaction outputs of alu_input_ctrl.
// slave: the front end itself; master: the board side / testbench.
interface alu_input_ctrl_if #(
    parameter int unsigned N = 2
);
    import alu_in_pkg::*;

    logic [N-1:0]      A_num;
    logic [N-1:0]      B_num;
    logic [OP_W-1:0]   operations_buttons;
    logic [MODE_W-1:0] change_mode;

    logic [N-1:0]      op_a;
    logic [N-1:0]      op_b;
    logic [OP_W-1:0]   op_sel;
    logic [MODE_W-1:0] mode;
    logic              op_valid;
    logic              op_err;
    logic              busy;

    modport master (
        output A_num, B_num, operations_buttons, change_mode,
        input  op_a, op_b, op_sel, mode, op_valid, op_err, busy
    );

    modport slave (
        input  A_num, B_num, operations_buttons, change_mode,
        output op_a, op_b, op_sel, mode, op_valid, op_err, busy
    );

endinterface

// File: rtl/alu_input_ctrl_button_debounce.sv
// Single-button debouncer: stable follows raw after DEB_CYCLES consecutive
// differing samples; rise pulses one cycle on each qualified 0->1 change.
module button_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (raw == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Registered rise lines up with the stable update edge.
                stable <= raw;
                rise   <= raw;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_input_ctrl.sv
// ALU input front end: debounces operation buttons, captures one transaction per press.
// Define ALU_IN_SYNC_EN to add a 2-flop synchronizer on all raw inputs.
module alu_input_ctrl
    import alu_in_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    alu_input_ctrl_if.slave  bus
);

    logic [N-1:0]      a_s;
    logic [N-1:0]      b_s;
    logic [OP_W-1:0]   btn_s;
    logic [MODE_W-1:0] mode_s;

`ifdef ALU_IN_SYNC_EN
    logic [N-1:0]      a_m;
    logic [N-1:0]      b_m;
    logic [OP_W-1:0]   btn_m;
    logic [MODE_W-1:0] mode_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_m    <= '0;
            b_m    <= '0;
            btn_m  <= '0;
            mode_m <= '0;
            a_s    <= '0;
            b_s    <= '0;
            btn_s  <= '0;
            mode_s <= '0;
        end else begin
            a_m    <= bus.A_num;
            b_m    <= bus.B_num;
            btn_m  <= bus.operations_buttons;
            mode_m <= bus.change_mode;
            a_s    <= a_m;
            b_s    <= b_m;
            btn_s  <= btn_m;
            mode_s <= mode_m;
        end
    end
`else
    always_comb begin
        a_s    = bus.A_num;
        b_s    = bus.B_num;
        btn_s  = bus.operations_buttons;
        mode_s = bus.change_mode;
    end
`endif

    logic [OP_W-1:0] stable;
    logic [OP_W-1:0] rise;

    for (genvar i = 0; i < OP_W; i++) begin : g_deb
        button_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw    (btn_s[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    state_e            state;
    logic [N-1:0]      op_a_r;
    logic [N-1:0]      op_b_r;
    logic [OP_W-1:0]   op_sel_r;
    logic [MODE_W-1:0] mode_r;
    logic              op_valid_r;
    logic              op_err_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_a_r     <= '0;
            op_b_r     <= '0;
            op_sel_r   <= '0;
            mode_r     <= '0;
            op_valid_r <= 1'b0;
            op_err_r   <= 1'b0;
        end else begin
            op_valid_r <= 1'b0;
            op_err_r   <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Judge the whole stable vector, so two bits rising together is an error.
                    if (rise != '0) begin
                        if (is_one_hot(stable)) begin
                            op_sel_r   <= stable;
                            op_a_r     <= a_s;
                            op_b_r     <= b_s;
                            mode_r     <= mode_s;
                            op_valid_r <= 1'b1;
                        end else begin
                            op_err_r   <= 1'b1;
                        end
                        state <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (stable == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.op_a     = op_a_r;
        bus.op_b     = op_b_r;
        bus.op_sel   = op_sel_r;
        bus.mode     = mode_r;
        bus.op_valid = op_valid_r;
        bus.op_err   = op_err_r;
        bus.busy     = (state == WAIT_REL);
    end

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Self-checking bench for alu_input_ctrl: vector table plus press-sequence corner cases,
// with a scoreboard of expected pulses (kind, cycle, captured values).
`timescale 1ns/1ps
module tb_alu_input_ctrl;
    import alu_in_pkg::*;

    localparam int unsigned N   = 2;
    localparam int unsigned DEB = 4;
`ifdef ALU_IN_SYNC_EN
    localparam int unsigned LAT = DEB + 3;
`else
    localparam int unsigned LAT = DEB + 1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    alu_input_ctrl_if #(.N(N)) bus ();

    alu_input_ctrl #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            err;
        logic [3:0]      sel;
        logic [N-1:0]    a;
        logic [N-1:0]    b;
        logic [1:0]      md;
        int unsigned     due;
    } exp_t;

    typedef struct {
        logic [3:0]   btn;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [1:0]   md;
        logic         exp_err;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        tv[8];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [3:0]   m_sel  = '0;
    logic [N-1:0] m_a    = '0;
    logic [N-1:0] m_b    = '0;
    logic [1:0]   m_mode = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.op_valid || bus.op_err) begin
                chk("pulse_exclusive", 32'(bus.op_valid & bus.op_err), 0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: valid=%0b err=%0b at cycle %0d, none expected",
                             bus.op_valid, bus.op_err, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_cycle", cyc, mon_e.due);
                    chk("pulse_is_err", 32'(bus.op_err), 32'(mon_e.err));
                    chk("op_sel", 32'(bus.op_sel), 32'(mon_e.sel));
                    chk("op_a", 32'(bus.op_a), 32'(mon_e.a));
                    chk("op_b", 32'(bus.op_b), 32'(mon_e.b));
                    chk("mode", 32'(bus.mode), 32'(mon_e.md));
                end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_pulse: nothing seen by cycle %0d, due at %0d", cyc, mon_e.due);
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] btn, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [1:0] md);
        bus.operations_buttons = btn;
        bus.A_num              = a;
        bus.B_num              = b;
        bus.change_mode        = md;
    endtask

    // Called right after the inputs change; the pulse is due LAT edges later.
    task automatic push(input logic [3:0] btn, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [1:0] md, input logic is_err);
        exp_t e;
        e.due = cyc + LAT;
        e.err = is_err;
        if (!is_err) begin
            m_sel  = btn;
            m_a    = a;
            m_b    = b;
            m_mode = md;
        end
        e.sel = m_sel;
        e.a   = m_a;
        e.b   = m_b;
        e.md  = m_mode;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int unsigned k = 0;
        while (sb.size() != 0 && k < 4 * LAT + 10) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: %0d pulses still pending", name, sb.size());
            sb.delete();
        end
        tick(1);
    endtask

    task automatic check_hold(input string name);
        chk({name, "_hold_sel"}, 32'(bus.op_sel), 32'(m_sel));
        chk({name, "_hold_a"}, 32'(bus.op_a), 32'(m_a));
        chk({name, "_hold_b"}, 32'(bus.op_b), 32'(m_b));
        chk({name, "_hold_mode"}, 32'(bus.mode), 32'(m_mode));
    endtask

    // busy must still be high one edge before the release is seen, and low right after.
    task automatic release_all(input string name);
        bus.operations_buttons = '0;
        tick(LAT - 1);
        chk({name, "_busy_before_idle"}, 32'(bus.busy), 1);
        tick(1);
        chk({name, "_busy_released"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{btn: 4'b0100, a: 2'b01, b: 2'b11, md: 2'b10, exp_err: 1'b0};
        tv[1] = '{btn: 4'b0001, a: 2'b10, b: 2'b00, md: 2'b01, exp_err: 1'b0};
        tv[2] = '{btn: 4'b0010, a: 2'b11, b: 2'b01, md: 2'b11, exp_err: 1'b0};
        tv[3] = '{btn: 4'b1000, a: 2'b00, b: 2'b10, md: 2'b00, exp_err: 1'b0};
        tv[4] = '{btn: 4'b0011, a: 2'b11, b: 2'b11, md: 2'b11, exp_err: 1'b1};
        tv[5] = '{btn: 4'b1100, a: 2'b01, b: 2'b01, md: 2'b01, exp_err: 1'b1};
        tv[6] = '{btn: 4'b0010, a: 2'b01, b: 2'b10, md: 2'b01, exp_err: 1'b0};
        tv[7] = '{btn: 4'b0111, a: 2'b10, b: 2'b10, md: 2'b10, exp_err: 1'b1};

        // Reset held 3 cycles with a button pressed: everything stays cleared.
        drive(4'b0100, 2'b11, 2'b11, 2'b11);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("reset_outputs", {bus.op_valid, bus.op_err, bus.busy, bus.op_sel,
                                  bus.op_a, bus.op_b, bus.mode}, 0);
        end
        drive(4'b0000, 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        tick(2);

        // Table: one press per vector, hold check while held and after release.
        for (int i = 0; i < 8; i++) begin
            drive(tv[i].btn, tv[i].a, tv[i].b, tv[i].md);
            push(tv[i].btn, tv[i].a, tv[i].b, tv[i].md, tv[i].exp_err);
            drain("vector");
            chk("busy_while_held", 32'(bus.busy), 1);
            bus.A_num       = N'($urandom);
            bus.B_num       = N'($urandom);
            bus.change_mode = 2'($urandom);
            tick(2);
            check_hold("held");
            release_all("vector");
            bus.A_num       = N'($urandom);
            bus.B_num       = N'($urandom);
            bus.change_mode = 2'($urandom);
            tick(3);
            check_hold("idle");
        end

        // Bouncing button 0: too short to qualify until finally held.
        for (int i = 0; i < 6; i++) begin
            drive((i % 2 == 0) ? 4'b0001 : 4'b0000, 2'b10, 2'b01, 2'b11);
            tick(2);
        end
        drive(4'b0001, 2'b10, 2'b01, 2'b11);
        push(4'b0001, 2'b10, 2'b01, 2'b11, 1'b0);
        drain("bounce");
        release_all("bounce");

        // Second button pressed while the first is held is ignored.
        drive(4'b0001, 2'b11, 2'b01, 2'b11);
        push(4'b0001, 2'b11, 2'b01, 2'b11, 1'b0);
        drain("hold_first");
        drive(4'b1001, 2'b00, 2'b00, 2'b00);
        tick(LAT + 3);
        chk("busy_second_ignored", 32'(bus.busy), 1);
        check_hold("second_ignored");
        release_all("second");
        drive(4'b1000, 2'b01, 2'b10, 2'b01);
        push(4'b1000, 2'b01, 2'b10, 2'b01, 1'b0);
        drain("after_ignore");
        release_all("after_ignore");

        // Reset two samples into debounce: held button must requalify from scratch.
        drive(4'b0010, 2'b10, 2'b10, 2'b01);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset  = 1'b0;
        m_sel  = '0;
        m_a    = '0;
        m_b    = '0;
        m_mode = '0;
        chk("midreset_cleared", {bus.op_valid, bus.op_err, bus.busy, bus.op_sel,
                                 bus.op_a, bus.op_b, bus.mode}, 0);
        push(4'b0010, 2'b10, 2'b10, 2'b01, 1'b0);
        drain("midreset");
        release_all("midreset");

        // Reset while waiting for release clears busy; the held button presses again.
        drive(4'b0100, 2'b01, 2'b11, 2'b10);
        push(4'b0100, 2'b01, 2'b11, 2'b10, 1'b0);
        drain("pre_waitrel_reset");
        reset = 1'b1;
        tick(1);
        reset  = 1'b0;
        m_sel  = '0;
        m_a    = '0;
        m_b    = '0;
        m_mode = '0;
        chk("waitrel_reset_busy", 32'(bus.busy), 0);
        push(4'b0100, 2'b01, 2'b11, 2'b10, 1'b0);
        drain("post_waitrel_reset");
        release_all("post_waitrel_reset");

        tick(2);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
